// File: rtl/lvds_tx_framer.sv
// Multi-lane LVDS transmit framer: FIFO-buffered user words, training/sync bring-up, idle fill.
// Optional periodic sync insertion in RUN when LVDS_TX_RESYNC_EN is defined.
//
// state  | meaning
// IDLE   | link down, outputs zero, FIFO flushed
// TRAIN  | training pattern for P_TRAIN_LEN cycles
// SYNC   | one sync word
// RUN    | user words from FIFO, idle pattern when empty
module lvds_tx_framer #(
  parameter int         P_IO_DW      = 18,
  parameter int         P_SER        = 8,
  parameter int         P_FIFO_AW    = 4,
  parameter int         P_TRAIN_LEN  = 64,
  parameter logic [7:0] P_TRAIN_PAT  = 8'hA5,
  parameter logic [7:0] P_SYNC_PAT   = 8'h3C,
  parameter logic [7:0] P_IDLE_PAT   = 8'h00,
  parameter int         P_RESYNC_INT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_en,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [P_IO_DW*P_SER-1:0]   s_data,
  output logic                       ser_dvld,
  output logic [P_IO_DW*P_SER-1:0]   ser_data,
  output logic                       ser_is_data,
  output logic [1:0]                 link_state,
  output logic [P_FIFO_AW:0]         fifo_level
);

  localparam int DW    = P_IO_DW * P_SER;
  localparam int DEPTH = 2 ** P_FIFO_AW;
  localparam int TW    = (P_TRAIN_LEN > 1) ? $clog2(P_TRAIN_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_SYNC  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {P_IO_DW{b[P_SER-1:0]}};
  endfunction

  state_t                 state, state_nxt;
  logic [TW-1:0]          train_cnt;
  logic [DW-1:0]          mem [DEPTH];
  logic [P_FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [P_FIFO_AW:0]     level, level_nxt;
  logic                   ready_q;
  logic                   wr_en, rd_en, resync_ins;
  logic                   dvld_nxt, is_data_nxt;
  logic [DW-1:0]          data_nxt;

  assign s_ready    = tx_en & ready_q;
  assign wr_en      = s_valid & s_ready;
  assign fifo_level = level;
  assign link_state = state;

`ifdef LVDS_TX_RESYNC_EN
  localparam int RW = (P_RESYNC_INT > 1) ? $clog2(P_RESYNC_INT) : 1;
  logic [RW-1:0] rs_cnt;
  logic          rs_sync_q;

  // rs_sync_q marks the inserted sync cycle so the count restarts after it
  assign resync_ins = (state == ST_RUN) && (state_nxt == ST_RUN) && !rs_sync_q && (rs_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_cnt    <= '0;
      rs_sync_q <= 1'b0;
    end else if (state != ST_RUN || state_nxt != ST_RUN) begin
      rs_cnt    <= RW'(P_RESYNC_INT - 1);
      rs_sync_q <= 1'b0;
    end else if (resync_ins) begin
      rs_cnt    <= RW'(P_RESYNC_INT - 1);
      rs_sync_q <= 1'b1;
    end else if (rs_sync_q) begin
      rs_sync_q <= 1'b0;
    end else begin
      rs_cnt <= rs_cnt - 1'b1;
    end
  end
`else
  assign resync_ins = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (!tx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_TRAIN;
        ST_TRAIN: if (train_cnt == '0) state_nxt = ST_SYNC;
        ST_SYNC:  state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered alongside the state, so they follow state_nxt
  always_comb begin
    rd_en       = 1'b0;
    dvld_nxt    = 1'b0;
    is_data_nxt = 1'b0;
    data_nxt    = '0;
    case (state_nxt)
      ST_TRAIN: begin
        dvld_nxt = 1'b1;
        data_nxt = rep(P_TRAIN_PAT);
      end
      ST_SYNC: begin
        dvld_nxt = 1'b1;
        data_nxt = rep(P_SYNC_PAT);
      end
      ST_RUN: begin
        dvld_nxt = 1'b1;
        if (resync_ins) begin
          data_nxt = rep(P_SYNC_PAT);
        end else if (level != '0) begin
          rd_en       = 1'b1;
          is_data_nxt = 1'b1;
          data_nxt    = mem[rd_ptr];
        end else begin
          data_nxt = rep(P_IDLE_PAT);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    level_nxt = level;
    if (!tx_en) begin
      level_nxt = '0;
    end else if (wr_en && !rd_en) begin
      level_nxt = level + 1'b1;
    end else if (!wr_en && rd_en) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      train_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_TRAIN) begin
        train_cnt <= TW'(P_TRAIN_LEN - 1);
      end else if (state == ST_TRAIN && train_cnt != '0) begin
        train_cnt <= train_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      level   <= level_nxt;
      ready_q <= (level_nxt < (P_FIFO_AW+1)'(DEPTH));
      if (!tx_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_dvld    <= 1'b0;
      ser_data    <= '0;
      ser_is_data <= 1'b0;
    end else begin
      ser_dvld    <= dvld_nxt;
      ser_data    <= data_nxt;
      ser_is_data <= is_data_nxt;
    end
  end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Self-checking bench for lvds_tx_framer (default build, 18 lanes x 8 bits, depth 16).
module tb_lvds_tx_framer;

  localparam int DW = 18 * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          ser_dvld;
  logic [DW-1:0] ser_data;
  logic          ser_is_data;
  logic [1:0]    link_state;
  logic [4:0]    fifo_level;

  lvds_tx_framer dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .ser_dvld    (ser_dvld),
    .ser_data    (ser_data),
    .ser_is_data (ser_is_data),
    .link_state  (link_state),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   rx_cnt  = 0;
  int   acc_cnt = 0;
  bit   chk_lat = 1'b0;

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {18{b}};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < 5; i++) w = (w << 32) | DW'($urandom());
    return w;
  endfunction

  // Scoreboard: compare the word registered at the previous edge, then record
  // the word the upcoming edge will accept.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (ser_is_data) begin
        checks++;
        rx_cnt++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stale_word got %h with no word outstanding", ser_data);
        end else begin
          e = q.pop_front();
          if (ser_data !== e.data) begin
            errors++;
            $display("FAIL data_order got %h expected %h", ser_data, e.data);
          end
          if (chk_lat) begin
            checks++;
            if (cyc - e.cyc != 2) begin
              errors++;
              $display("FAIL latency got %0d expected 2", cyc - e.cyc);
            end
          end
        end
      end
      if (!tx_en) q.delete();
      else if (s_valid && s_ready) begin
        q.push_back('{data: s_data, cyc: cyc});
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input int maxc);
    int n = 0;
    while (link_state !== st && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (link_state !== st) begin
      errors++;
      $display("FAIL wait_state got %0d expected %0d", link_state, st);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b0; s_valid = 1'b0; s_data = '0;
    #12;
    checks++;
    if ({ser_dvld, ser_is_data, s_ready} !== 3'b000 || ser_data !== '0 ||
        link_state !== 2'd0 || fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL reset_values dvld=%b isd=%b rdy=%b st=%0d lvl=%0d", ser_dvld, ser_is_data,
               s_ready, link_state, fifo_level);
    end
    #10 rst = 1'b0;
    step();
    step();
    checks++;
    if (link_state !== 2'd0 || ser_dvld !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset st=%0d dvld=%b rdy=%b", link_state, ser_dvld, s_ready);
    end
  endtask

  task automatic test_bringup();
    int bad = 0;
    tx_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (link_state !== 2'd1 || ser_data !== rep(8'hA5) || ser_dvld !== 1'b1 || ser_is_data !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL train_cycles got %0d bad cycles expected 0", bad);
    end
    step();
    checks++;
    if (link_state !== 2'd2 || ser_data !== rep(8'h3C) || ser_dvld !== 1'b1) begin
      errors++;
      $display("FAIL sync_word st=%0d data=%h", link_state, ser_data);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (link_state !== 2'd3 || ser_data !== rep(8'h00) || ser_dvld !== 1'b1 || ser_is_data !== 1'b0) begin
        errors++;
        $display("FAIL run_idle st=%0d data=%h dvld=%b isd=%b", link_state, ser_data, ser_dvld, ser_is_data);
      end
    end
  endtask

  task automatic test_stream5();
    int rx0 = rx_cnt;
    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = rep(8'(i + 1));
      step();
    end
    s_valid = 1'b0;
    repeat (5) step();
    chk_lat = 1'b0;
    checks++;
    if (rx_cnt - rx0 != 5) begin
      errors++;
      $display("FAIL stream5_count got %0d expected 5", rx_cnt - rx0);
    end
    checks++;
    if (ser_is_data !== 1'b0 || ser_data !== rep(8'h00)) begin
      errors++;
      $display("FAIL stream5_idle isd=%b data=%h", ser_is_data, ser_data);
    end
  endtask

  task automatic test_fill_in_train();
    int acc0, rx0;
    tx_en = 1'b0;
    step();
    acc0 = acc_cnt;
    rx0  = rx_cnt;
    tx_en = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = rand_word();
      step();
    end
    checks++;
    if (acc_cnt - acc0 != 16) begin
      errors++;
      $display("FAIL fill_accepted got %0d expected 16", acc_cnt - acc0);
    end
    checks++;
    if (s_ready !== 1'b0 || fifo_level !== 5'd16) begin
      errors++;
      $display("FAIL fill_full rdy=%b lvl=%0d expected 0/16", s_ready, fifo_level);
    end
    s_valid = 1'b0;
    wait_state(2'd3, 80);
    repeat (20) step();
    checks++;
    if (rx_cnt - rx0 != 16) begin
      errors++;
      $display("FAIL drain_count got %0d expected 16", rx_cnt - rx0);
    end
    checks++;
    if (s_ready !== 1'b1 || fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL drain_ready rdy=%b lvl=%0d expected 1/0", s_ready, fifo_level);
    end
  endtask

  task automatic test_disable_flush();
    int rx0;
    tx_en = 1'b0;
    step();
    tx_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = rand_word();
      step();
    end
    s_valid = 1'b0;
    checks++;
    if (fifo_level !== 5'd7 || link_state !== 2'd1) begin
      errors++;
      $display("FAIL pre_flush lvl=%0d st=%0d expected 7/1", fifo_level, link_state);
    end
    rx0 = rx_cnt;
    tx_en = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_gate got %b expected 0", s_ready);
    end
    step();
    checks++;
    if (link_state !== 2'd0 || ser_dvld !== 1'b0 || fifo_level !== 5'd0 || ser_data !== '0) begin
      errors++;
      $display("FAIL flush st=%0d dvld=%b lvl=%0d", link_state, ser_dvld, fifo_level);
    end
    test_bringup();
    repeat (10) step();
    checks++;
    if (rx_cnt != rx0) begin
      errors++;
      $display("FAIL no_stale got %0d words expected 0", rx_cnt - rx0);
    end
  endtask

  task automatic test_reset_mid_run();
    tx_en = 1'b0;
    step();
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = rand_word();
      step();
    end
    s_valid = 1'b0;
    wait_state(2'd3, 80);
    checks++;
    if (fifo_level !== 5'd7 || ser_is_data !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset lvl=%0d isd=%b expected 7/1", fifo_level, ser_is_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ser_dvld, ser_is_data} !== 2'b00 || ser_data !== '0 || link_state !== 2'd0 ||
        fifo_level !== 5'd0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset dvld=%b isd=%b st=%0d lvl=%0d rdy=%b", ser_dvld, ser_is_data,
               link_state, fifo_level, s_ready);
    end
    tx_en = 1'b0;
    repeat (2) step();
    #2 rst = 1'b0;
    repeat (3) step();
    checks++;
    if (link_state !== 2'd0 || fifo_level !== 5'd0 || ser_dvld !== 1'b0) begin
      errors++;
      $display("FAIL post_reset st=%0d lvl=%0d dvld=%b", link_state, fifo_level, ser_dvld);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stream5();
    test_fill_in_train();
    test_disable_flush();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
